// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the EX stage.
// One shift-add / shift-subtract step per cycle; HI/LO result.
module muldiv_iter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              annul,
  output logic              stallreq,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_by_zero
);

  localparam int W = DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2*W:0]     acc;
  logic [W-1:0]     opnd;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             res_neg;
  logic             rem_neg;

  logic             a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;
  logic             zero_fast;
  logic             launch;
  logic             last;

  logic [W:0]       sum;
  logic [2*W:0]     mul_nx;
  logic [W:0]       rem_sh;
  logic [W:0]       diff;
  logic             ge;
  logic [2*W:0]     div_nx;
  logic [2*W:0]     acc_nx;

  logic [2*W-1:0]   prod;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quot_fix;
  logic [W-1:0]     rem_fix;

  // Operand magnitudes and launch conditions seen in IDLE.
  always_comb begin
    a_neg     = ~op[0] & src_a[W-1];
    b_neg     = ~op[0] & src_b[W-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
    zero_fast = op[1] & (src_b == '0);
    launch    = (state_q == IDLE) & start & ~annul;
    last      = (state_q == RUN) & (cnt == CNT_W'(W - 1));
  end

  // One iteration step plus sign correction of the final value.
  always_comb begin
    sum    = acc[2*W:W] + {1'b0, opnd};
    mul_nx = acc[0] ? ({sum, acc[W-1:0]} >> 1) : (acc >> 1);
    rem_sh = {acc[2*W-1:W], acc[W-1]};
    diff   = rem_sh - {1'b0, opnd};
    ge     = rem_sh >= {1'b0, opnd};
    div_nx = {ge ? diff : rem_sh, acc[W-2:0], ge};
    acc_nx = is_div ? div_nx : mul_nx;

    prod     = acc_nx[2*W-1:0];
    prod_fix = res_neg ? -prod : prod;
    quot_fix = res_neg ? -acc_nx[W-1:0] : acc_nx[W-1:0];
    rem_fix  = rem_neg ? -acc_nx[2*W-1:W] : acc_nx[2*W-1:W];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    stallreq = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d  = zero_fast ? DONE : RUN;
          stallreq = ~zero_fast;
        end
      end
      RUN: begin
        busy     = 1'b1;
        stallreq = 1'b1;
        if (annul)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = ~annul;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration and result write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      opnd        <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (launch) begin
      if (zero_fast) begin
        hi          <= src_a;
        lo          <= '1;
        div_by_zero <= 1'b1;
      end else begin
        acc     <= {{(W+1){1'b0}}, op[1] ? a_mag : b_mag};
        opnd    <= op[1] ? b_mag : a_mag;
        is_div  <= op[1];
        res_neg <= a_neg ^ b_neg;
        rem_neg <= a_neg;
        cnt     <= '0;
      end
    end else if (state_q == RUN && !annul) begin
      acc <= acc_nx;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        div_by_zero <= 1'b0;
        if (is_div) begin
          hi <= rem_fix;
          lo <= quot_fix;
        end else begin
          hi <= prod_fix[2*W-1:W];
          lo <= prod_fix[W-1:0];
        end
      end
    end
  end

endmodule
